// File: rtl/qec_round_scheduler.sv
// qec_round_scheduler
//   Sequences syndrome-extraction rounds for the 5-qubit code. It keeps requesting
//   ancilla measurements until the same syndrome has been seen CONFIRM times in a row.
//   It then holds that syndrome on the shared decoder LUT and collects the X/Y/Z
//   correction slots. Finally it emits a merged Pauli frame to the correction-apply stage.
// Ports
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   start               pulse, begins a correction cycle when idle
//   meas_req/valid/syn  measurement-round handshake with the readout front end
//   dec_ancilla         syndrome presented to the decoder LUT
//   dec_correction/axis decoder answer: 5-bit correction tagged 00 none, 01 X, 10 Y, 11 Z
//   frame_valid/ready   frame handshake toward the consumer
//   frame_x/z/err       merged Pauli frame; x/z are forced to 0 when err is set
//   rounds_used         measurement rounds consumed, valid with frame_valid
//   busy                high whenever not idle
module qec_round_scheduler #(
  parameter int DEC_LAT    = 3,
  parameter int CONFIRM    = 2,
  parameter int MAX_ROUNDS = 8,
  parameter int COLLECT_TO = 6
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  output logic       meas_req,
  input  logic       meas_valid,
  input  logic [3:0] meas_syn,
  output logic [3:0] dec_ancilla,
  input  logic [4:0] dec_correction,
  input  logic [1:0] dec_axis,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic [4:0] frame_x,
  output logic [4:0] frame_z,
  output logic       frame_err,
  output logic [3:0] rounds_used,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_MEAS, S_CHECK, S_SETTLE, S_COLLECT, S_OUT
  } state_t;

  state_t     r_state, w_next;
  logic [3:0] r_cur_syn, r_prev_syn, r_match_cnt, r_round_cnt, r_dec_anc;
  logic [4:0] r_cx, r_cy, r_cz, r_fx, r_fz;
  logic [2:0] r_seen;
  logic [7:0] r_tmr;
  logic       r_ferr;

  logic       w_hs, w_confirm, w_settle_done, w_collect_to, w_all_seen;
  logic [3:0] w_match;
  logic [4:0] w_cx, w_cy, w_cz;
  logic [2:0] w_seen;
  logic [10:0] w_merged;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // {err, x, z}: exactly one nonzero slot is a legal single-qubit Pauli; Y sets both x and z.
  function automatic logic [10:0] merge_frame(input logic [4:0] cx, input logic [4:0] cy,
                                              input logic [4:0] cz);
    logic [2:0] nz;
    logic       err;
    nz  = {|cx, |cy, |cz};
    err = !(nz == 3'b100 || nz == 3'b010 || nz == 3'b001);
    return err ? {1'b1, 10'd0} : {1'b0, cx | cy, cz | cy};
  endfunction

  assign w_hs          = (r_state == S_MEAS) && meas_valid;
  // First round of a cycle always restarts the run, regardless of the stale prev_syn.
  assign w_match       = (r_round_cnt == 4'd1 || r_cur_syn != r_prev_syn) ? 4'd1
                                                                          : sat_inc(r_match_cnt);
  assign w_confirm     = (w_match == 4'(CONFIRM));
  assign w_settle_done = (r_tmr == 8'(DEC_LAT - 1));
  assign w_collect_to  = (r_tmr == 8'(COLLECT_TO - 1));

  always_comb begin
    w_cx   = r_cx;
    w_cy   = r_cy;
    w_cz   = r_cz;
    w_seen = r_seen;
    case (dec_axis)
      2'b01:   begin w_cx = dec_correction; w_seen[0] = 1'b1; end
      2'b10:   begin w_cy = dec_correction; w_seen[1] = 1'b1; end
      2'b11:   begin w_cz = dec_correction; w_seen[2] = 1'b1; end
      default: ;
    endcase
  end

  assign w_all_seen = &w_seen;
  assign w_merged   = merge_frame(w_cx, w_cy, w_cz);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_MEAS;
      S_MEAS:    if (w_hs) w_next = S_CHECK;
      S_CHECK: begin
        if (w_confirm)                          w_next = (r_cur_syn == 4'd0) ? S_OUT : S_SETTLE;
        else if (r_round_cnt == 4'(MAX_ROUNDS)) w_next = S_OUT;
        else                                    w_next = S_MEAS;
      end
      S_SETTLE:  if (w_settle_done) w_next = S_COLLECT;
      S_COLLECT: if (w_all_seen || w_collect_to) w_next = S_OUT;
      S_OUT:     if (frame_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cur_syn   <= '0;
      r_prev_syn  <= '0;
      r_match_cnt <= '0;
      r_round_cnt <= '0;
      r_dec_anc   <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_cz        <= '0;
      r_seen      <= '0;
      r_tmr       <= '0;
      r_fx        <= '0;
      r_fz        <= '0;
      r_ferr      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_round_cnt <= '0;
          r_match_cnt <= '0;
          r_cx        <= '0;
          r_cy        <= '0;
          r_cz        <= '0;
          r_seen      <= '0;
        end
        S_MEAS: if (w_hs) begin
          r_cur_syn   <= meas_syn;
          r_round_cnt <= sat_inc(r_round_cnt);
        end
        S_CHECK: begin
          r_match_cnt <= w_match;
          r_prev_syn  <= r_cur_syn;
          r_tmr       <= '0;
          if (w_confirm) begin
            r_fx   <= '0;
            r_fz   <= '0;
            r_ferr <= 1'b0;
            if (r_cur_syn != 4'd0) r_dec_anc <= r_cur_syn;
          end else if (r_round_cnt == 4'(MAX_ROUNDS)) begin
            r_fx   <= '0;
            r_fz   <= '0;
            r_ferr <= 1'b1;
          end
        end
        S_SETTLE: r_tmr <= w_settle_done ? 8'd0 : r_tmr + 8'd1;
        S_COLLECT: begin
          r_cx   <= w_cx;
          r_cy   <= w_cy;
          r_cz   <= w_cz;
          r_seen <= w_seen;
          r_tmr  <= r_tmr + 8'd1;
          if (w_all_seen) begin
            {r_ferr, r_fx, r_fz} <= w_merged;
            r_dec_anc            <= '0;
          end else if (w_collect_to) begin
            r_fx      <= '0;
            r_fz      <= '0;
            r_ferr    <= 1'b1;
            r_dec_anc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign meas_req    = (r_state == S_MEAS);
  assign busy        = (r_state != S_IDLE);
  assign frame_valid = (r_state == S_OUT);
  assign frame_x     = frame_valid ? r_fx : 5'd0;
  assign frame_z     = frame_valid ? r_fz : 5'd0;
  assign frame_err   = frame_valid & r_ferr;
  assign rounds_used = frame_valid ? r_round_cnt : 4'd0;
  assign dec_ancilla = r_dec_anc;

endmodule
